sigma_delta_decimator: RTL and testbench

Receive-side counterpart to `sigma_delta_converter`. The block takes a 1-bit pulse-density stream, either from that DAC in loopback or from an external sigma-delta modulator, and rebuilds multi-bit audio samples. It uses a second-order CIC (sinc²) decimation filter. Each decimated sample is presented on `audio_out` with a one-cycle `audio_valid` strobe, for capture by downstream synth/monitor logic.

---
 rtl/sigma_delta_decimator_pkg.sv | 33 +++
 rtl/sigma_delta_decimator_if.sv | 14 +
 rtl/sigma_delta_decimator_cic2_comb.sv | 90 +++++++++
 rtl/sigma_delta_decimator.sv | 59 +++++
 tb/tb_sigma_delta_decimator.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/sigma_delta_decimator_pkg.sv
// Shared types and helpers for the sinc^2 sigma-delta decimator.
package sigma_delta_pkg;

   // Warm-up sequencing: the first two comb results are pipeline fill.
   typedef enum logic [1:0] {
      WARM0 = 2'd0,
      WARM1 = 2'd1,
      RUN   = 2'd2
   } warm_state_t;

   // Integrator/comb width: enough to hold R^2 plus one guard bit.
   function automatic int cic_width(input int log2_dec);
      return 2 * log2_dec + 1;
   endfunction

   // Clamp a comb result to the output range and take its top bits.
   // The true result never exceeds R^2, which is the only value that
   // needs the all-ones clamp.
   function automatic logic [31:0] sat(input logic [31:0] c2,
                                       input int log2_dec,
                                       input int aw);
      logic [31:0] r2;
      logic [31:0] mask;
      r2   = 32'd1 << (2 * log2_dec);
      mask = (32'd1 << aw) - 32'd1;
      if (c2 >= r2) begin
         sat = mask;
      end else begin
         sat = (c2 >> (2 * log2_dec - aw)) & mask;
      end
   endfunction

endpackage

// File: rtl/sigma_delta_decimator_if.sv
// Pulse-density input and decoded-audio output bundle.
interface sigma_delta_decimator_if #(
   parameter int AUDIO_WIDTH = 8
);
   logic                   pdm_in;
   logic                   pdm_valid;
   logic [AUDIO_WIDTH-1:0] audio_out;
   logic                   audio_valid;

   modport master (output pdm_in, output pdm_valid,
                   input  audio_out, input audio_valid);
   modport slave  (input  pdm_in, input pdm_valid,
                   output audio_out, output audio_valid);
endinterface

// File: rtl/sigma_delta_decimator_cic2_comb.sv
// Decimated half of the CIC: window snapshot, two differencers,
// saturation and the warm-up sequencer that suppresses fill results.
module cic2_comb
   import sigma_delta_pkg::*;
#(
   parameter int AUDIO_WIDTH     = 8,
   parameter int LOG2_DECIMATION = 4
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic                              load,
   input  logic [cic_width(LOG2_DECIMATION)-1:0] i2_n,
   output logic [AUDIO_WIDTH-1:0]            audio_out,
   output logic                              audio_valid
);
   localparam int W = cic_width(LOG2_DECIMATION);

   logic [W-1:0]           snap;
   logic                   snap_stb;
   logic [W-1:0]           s_prev;
   logic [W-1:0]           c1_prev;
   logic [W-1:0]           c1;
   logic [W-1:0]           c2;
   logic [AUDIO_WIDTH-1:0] sat_val;
   warm_state_t            state;
   warm_state_t            state_n;
   logic                   strobe_en;

   // Differences wrap modulo 2^W; the real result always fits in 0..R^2.
   assign c1      = snap - s_prev;
   assign c2      = c1 - c1_prev;
   assign sat_val = AUDIO_WIDTH'(sat(32'(c2), LOG2_DECIMATION, AUDIO_WIDTH));

   // Capture the second integrator at the close of each window.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         snap     <= '0;
         snap_stb <= 1'b0;
      end else begin
         snap_stb <= load;
         if (load) begin
            snap <= i2_n;
         end
      end
   end

   // Comb update one edge after the snapshot; strobe only once warmed up.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s_prev      <= '0;
         c1_prev     <= '0;
         audio_out   <= '0;
         audio_valid <= 1'b0;
      end else begin
         audio_valid <= snap_stb && strobe_en;
         if (snap_stb) begin
            s_prev    <= snap;
            c1_prev   <= c1;
            audio_out <= sat_val;
         end
      end
   end

   // Warm-up state register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= WARM0;
      end else begin
         state <= state_n;
      end
   end

   // Advance one step per comb update; RUN is absorbing.
   always_comb begin
      state_n = state;
      if (snap_stb) begin
         case (state)
            WARM0:   state_n = WARM1;
            WARM1:   state_n = RUN;
            default: state_n = RUN;
         endcase
      end
   end

   // Strobes are allowed only once the comb history is real data.
   always_comb begin
      strobe_en = (state == RUN);
   end

endmodule

// File: rtl/sigma_delta_decimator.sv
// Sinc^2 decimator: full-rate integrators and window counter here,
// decimated comb and warm-up handling in cic2_comb.
module sigma_delta_decimator
   import sigma_delta_pkg::*;
#(
   parameter int AUDIO_WIDTH     = 8,
   parameter int LOG2_DECIMATION = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   sigma_delta_decimator_if.slave bus
);
   localparam int W = cic_width(LOG2_DECIMATION);

   logic [W-1:0]               i1;
   logic [W-1:0]               i2;
   logic [W-1:0]               i1_n;
   logic [W-1:0]               i2_n;
   logic [W-1:0]               x;
   logic [LOG2_DECIMATION-1:0] cnt;
   logic                       load;
   logic [AUDIO_WIDTH-1:0]     audio_out;
   logic                       audio_valid;

   assign x    = {{(W-1){1'b0}}, bus.pdm_in};
   assign i1_n = i1 + x;
   assign i2_n = i2 + i1_n;
   // The last bit of a window is the one accepted with the counter at R-1.
   assign load = bus.pdm_valid && (&cnt);

   // Integrate accepted bits and count them within the window.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         i1  <= '0;
         i2  <= '0;
         cnt <= '0;
      end else if (bus.pdm_valid) begin
         i1  <= i1_n;
         i2  <= i2_n;
         cnt <= cnt + LOG2_DECIMATION'(1);
      end
   end

   cic2_comb #(
      .AUDIO_WIDTH     (AUDIO_WIDTH),
      .LOG2_DECIMATION (LOG2_DECIMATION)
   ) u_comb (
      .clock       (clock),
      .reset       (reset),
      .load        (load),
      .i2_n        (i2_n),
      .audio_out   (audio_out),
      .audio_valid (audio_valid)
   );

   assign bus.audio_out   = audio_out;
   assign bus.audio_valid = audio_valid;

endmodule

// File: tb/tb_sigma_delta_decimator.sv
// Bench for sigma_delta_decimator: a triangular-FIR reference checks every
// cycle, plus scenario tables and hand-written corner sequences.
module tb_sigma_delta_decimator;
   localparam int AW = 8;
   localparam int L  = 4;
   localparam int R  = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sigma_delta_decimator_if #(.AUDIO_WIDTH(AW)) bus ();

   sigma_delta_decimator #(
      .AUDIO_WIDTH     (AW),
      .LOG2_DECIMATION (L)
   ) dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int st_cyc[$];
   int st_val[$];

   // reference model state
   int hist[$];
   int m_cnt = 0, m_win = 0, pend = 0, pend_val = 0, pend_win = 0;
   int e_out = 0, e_valid = 0;

   typedef struct {
      int mode;     // 0 zeros, 1 ones, 2 alternating
      int period;   // pdm_valid high one clock in 'period'
      int windows;
      int exp_val;
      int exp_gap;
   } vec_t;
   vec_t vecs[4];

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      total++;
      if (act < lo || act > hi) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   // Reference: a sinc^2 filter is a triangular FIR of length 2R-1 over the
   // accepted bits, evaluated once per R accepted bits.
   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         if (rst) begin
            hist.delete();
            m_cnt = 0; m_win = 0; pend = 0; e_out = 0; e_valid = 0;
         end else begin
            e_valid = 0;
            if (pend != 0) begin
               e_out   = pend_val;
               e_valid = (pend_win >= 3) ? 1 : 0;
            end
            pend = 0;
            if (bus.pdm_valid) begin
               hist.push_back(int'(bus.pdm_in));
               if (hist.size() > 2*R-1) void'(hist.pop_front());
               m_cnt++;
               if (m_cnt == R) begin
                  int y;
                  y = 0;
                  m_cnt = 0;
                  m_win++;
                  for (int k = 0; k < hist.size(); k++) begin
                     int h;
                     h = (k < R) ? k + 1 : 2*R - 1 - k;
                     y += h * hist[hist.size()-1-k];
                  end
                  pend     = 1;
                  pend_val = (y >= R*R) ? (1 << AW) - 1 : (y >> (2*L - AW)) & ((1 << AW) - 1);
                  pend_win = m_win;
               end
            end
         end
         #1;
         check("valid", int'(bus.audio_valid), e_valid);
         check("audio_out", int'(bus.audio_out), e_out);
         if (bus.audio_valid) begin
            st_cyc.push_back(cyc);
            st_val.push_back(int'(bus.audio_out));
         end
      end
   end

   task automatic tick(input logic v, input logic b);
      @(negedge clk);
      bus.pdm_valid = v;
      bus.pdm_in    = b;
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      rst = 1'b1;
      bus.pdm_valid = 1'b0;
      bus.pdm_in    = 1'b0;
      repeat (n) @(negedge clk);
      rst = 1'b0;
      st_cyc.delete();
      st_val.delete();
   endtask

   task automatic run_vec(input vec_t vv);
      logic alt;
      logic v;
      logic b;
      alt = 1'b1;
      do_reset(2);
      for (int c = 0; c < vv.windows * R * vv.period; c++) begin
         v = ((c % vv.period) == 0);
         b = (vv.mode == 1) ? 1'b1 : (vv.mode == 0) ? 1'b0 : alt;
         if (v && vv.mode == 2) alt = ~alt;
         tick(v, b);
      end
      repeat (3) tick(1'b0, 1'b0);
      check("n_strobes", st_val.size(), vv.windows - 2);
      for (int i = 0; i < st_val.size(); i++) begin
         check("steady_val", st_val[i], vv.exp_val);
         if (i > 0) check("strobe_gap", st_cyc[i] - st_cyc[i-1], vv.exp_gap);
      end
   endtask

   initial begin
      int n0;
      int acc;
      int ain;
      int base;
      int s;
      bus.pdm_valid = 1'b0;
      bus.pdm_in    = 1'b0;

      vecs[0] = '{mode: 1, period: 1, windows: 6, exp_val: 255, exp_gap: 16};
      vecs[1] = '{mode: 0, period: 1, windows: 6, exp_val: 0,   exp_gap: 16};
      vecs[2] = '{mode: 2, period: 1, windows: 6, exp_val: 128, exp_gap: 16};
      vecs[3] = '{mode: 1, period: 3, windows: 6, exp_val: 255, exp_gap: 48};

      // reset state
      @(posedge clk); #1;
      check("reset_out", int'(bus.audio_out), 0);
      check("reset_valid", int'(bus.audio_valid), 0);

      for (int i = 0; i < 4; i++) run_vec(vecs[i]);

      // gated input with a long pdm_valid-low hold mid-window
      do_reset(2);
      for (int c = 0; c < 4*48 + 5*3; c++) tick((c % 3) == 0, 1'b1);
      n0 = st_val.size();
      check("hold_pre_strobes", n0, 2);
      repeat (100) tick(1'b0, 1'b1);
      check("hold_no_strobe", st_val.size(), n0);
      for (int c = 0; c < 11*3; c++) tick((c % 3) == 0, 1'b1);
      repeat (3) tick(1'b0, 1'b0);
      check("hold_next_strobe", st_val.size(), n0 + 1);
      if (st_val.size() > 0) check("hold_val", st_val[st_val.size()-1], 255);

      // mid-window reset, 7 bits into the fourth window
      do_reset(2);
      for (int c = 0; c < 3*R + 7; c++) tick(1'b1, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         check("rst_mid_out", int'(bus.audio_out), 0);
         check("rst_mid_valid", int'(bus.audio_valid), 0);
      end
      @(negedge clk);
      rst = 1'b0;
      st_cyc.delete();
      st_val.delete();
      for (int c = 0; c < 2*R + 2; c++) tick(1'b1, 1'b1);
      check("rst_warm_quiet", st_val.size(), 0);
      for (int c = 0; c < 3*R - 2; c++) tick(1'b1, 1'b1);
      repeat (3) tick(1'b0, 1'b0);
      check("rst_after_strobes", st_val.size(), 3);
      if (st_val.size() > 0) check("rst_third_val", st_val[0], 255);

      // loopback from a first-order sigma-delta modulator
      do_reset(2);
      acc = 0;
      for (int ph = 0; ph < 2; ph++) begin
         ain  = (ph == 0) ? 100 : 200;
         base = st_val.size();
         for (int c = 0; c < 12*R; c++) begin
            s   = acc + ain;
            acc = s & 255;
            tick(1'b1, s >= 256);
         end
         for (int i = base + 2; i < st_val.size(); i++)
            check_range("loopback", st_val[i], ain - 16, ain + 16);
      end

      // random bits, random gating, occasional reset
      do_reset(2);
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 399) == 0) do_reset(2);
         tick($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
      end
      repeat (3) tick(1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
